// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache: default widths common with the
// fetcher, FSM state encoding and address-field offset helpers.
package icache_pkg;

   localparam int ICACHE_ADDR_WIDTH     = 32;
   localparam int ICACHE_INST_WIDTH     = 32;
   localparam int ICACHE_INDEX_BITS     = 6;
   localparam int ICACHE_LINE_WORDS_LOG = 2;
   localparam int ICACHE_WORD_LSB       = 2;

   typedef enum logic [1:0] {
      ICACHE_IDLE = 2'd0,
      ICACHE_FILL = 2'd1,
      ICACHE_RESP = 2'd2
   } icache_state_t;

   function automatic int icache_index_lsb(input int line_words_log);
      return ICACHE_WORD_LSB + line_words_log;
   endfunction

   function automatic int icache_tag_lsb(input int index_bits, input int line_words_log);
      return icache_index_lsb(line_words_log) + index_bits;
   endfunction

endpackage

// File: rtl/icache_array.sv
// Valid/tag/data storage for the direct-mapped instruction cache.
// Reads are combinational by index; all writes land on the clock edge.
module icache_array
   import icache_pkg::*;
#(
   parameter int INST_WIDTH     = ICACHE_INST_WIDTH,
   parameter int INDEX_BITS     = ICACHE_INDEX_BITS,
   parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG,
   parameter int TAG_BITS       = 22
)(
   input  logic                      clk,
   input  logic                      rst,
   input  logic [INDEX_BITS-1:0]     rd_index,
   input  logic [LINE_WORDS_LOG-1:0] rd_word,
   output logic                      rd_valid,
   output logic [TAG_BITS-1:0]       rd_tag,
   output logic [INST_WIDTH-1:0]     rd_data,
   input  logic [INDEX_BITS-1:0]     wr_index,
   input  logic [LINE_WORDS_LOG-1:0] wr_word,
   input  logic [INST_WIDTH-1:0]     wr_data,
   input  logic                      word_we,
   input  logic                      line_inv,
   input  logic                      tag_we,
   input  logic [TAG_BITS-1:0]       wr_tag
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int DEPTH = LINES << LINE_WORDS_LOG;

   logic [LINES-1:0]      valid_reg;
   logic [TAG_BITS-1:0]   tag_mem  [LINES];
   logic [INST_WIDTH-1:0] data_mem [DEPTH];

   // Only the valid bits need a reset; tag/data contents are meaningless until valid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= '0;
      end else begin
         if (line_inv) valid_reg[wr_index] <= 1'b0;
         if (tag_we)   valid_reg[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) tag_mem[wr_index] <= wr_tag;
   end

   always_ff @(posedge clk) begin
      if (word_we) data_mem[{wr_index, wr_word}] <= wr_data;
   end

   assign rd_valid = valid_reg[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[{rd_index, rd_word}];

endmodule

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache between the fetcher and the memory
// controller; misses refill a whole line one word per memory request.
module icache
   import icache_pkg::*;
#(
   parameter int ADDR_WIDTH     = ICACHE_ADDR_WIDTH,
   parameter int INST_WIDTH     = ICACHE_INST_WIDTH,
   parameter int INDEX_BITS     = ICACHE_INDEX_BITS,
   parameter int LINE_WORDS_LOG = ICACHE_LINE_WORDS_LOG
)(
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  rdy,
   input  logic                  flush,
   input  logic                  if_req_valid,
   input  logic [ADDR_WIDTH-1:0] if_req_addr,
   output logic                  if_resp_done,
   output logic [INST_WIDTH-1:0] if_resp_data,
   output logic                  mem_req_valid,
   output logic [ADDR_WIDTH-1:0] mem_req_addr,
   input  logic                  mem_resp_done,
   input  logic [INST_WIDTH-1:0] mem_resp_data
);

   localparam int INDEX_LSB = icache_index_lsb(LINE_WORDS_LOG);
   localparam int TAG_LSB   = icache_tag_lsb(INDEX_BITS, LINE_WORDS_LOG);
   localparam int TAG_BITS  = ADDR_WIDTH - TAG_LSB;
   localparam logic [LINE_WORDS_LOG-1:0] LAST_WORD = '1;

   icache_state_t                       state_reg, state_next;
   logic [ADDR_WIDTH-1:ICACHE_WORD_LSB] fill_addr_reg, fill_addr_next;
   logic [LINE_WORDS_LOG-1:0]           cnt_reg, cnt_next, cnt_inc;
   logic                                drop_reg, drop_next;
   logic                                done_reg, done_next;
   logic [INST_WIDTH-1:0]               data_reg, data_next;
   logic                                mreq_reg, mreq_next;
   logic [ADDR_WIDTH-1:0]               maddr_reg, maddr_next;

   logic [INDEX_BITS-1:0]     req_index, fill_index;
   logic [LINE_WORDS_LOG-1:0] req_word, fill_word;
   logic [TAG_BITS-1:0]       req_tag, fill_tag;
   logic                      rd_valid, hit;
   logic [TAG_BITS-1:0]       rd_tag;
   logic [INST_WIDTH-1:0]     rd_data;
   logic                      word_we, tag_we, line_inv;
   logic                      unused_offset;

   assign req_index     = if_req_addr[TAG_LSB-1:INDEX_LSB];
   assign req_word      = if_req_addr[INDEX_LSB-1:ICACHE_WORD_LSB];
   assign req_tag       = if_req_addr[ADDR_WIDTH-1:TAG_LSB];
   assign fill_index    = fill_addr_reg[TAG_LSB-1:INDEX_LSB];
   assign fill_word     = fill_addr_reg[INDEX_LSB-1:ICACHE_WORD_LSB];
   assign fill_tag      = fill_addr_reg[ADDR_WIDTH-1:TAG_LSB];
   assign unused_offset = ^if_req_addr[ICACHE_WORD_LSB-1:0];
   assign cnt_inc       = cnt_reg + LINE_WORDS_LOG'(1);
   assign hit           = rd_valid && (rd_tag == req_tag);

   icache_array #(
      .INST_WIDTH     (INST_WIDTH),
      .INDEX_BITS     (INDEX_BITS),
      .LINE_WORDS_LOG (LINE_WORDS_LOG),
      .TAG_BITS       (TAG_BITS)
   ) u_array (
      .clk      (clk),
      .rst      (rst),
      .rd_index (req_index),
      .rd_word  (req_word),
      .rd_valid (rd_valid),
      .rd_tag   (rd_tag),
      .rd_data  (rd_data),
      .wr_index ((state_reg == ICACHE_IDLE) ? req_index : fill_index),
      .wr_word  (cnt_reg),
      .wr_data  (mem_resp_data),
      .word_we  (word_we & rdy),
      .line_inv (line_inv & rdy),
      .tag_we   (tag_we & rdy),
      .wr_tag   (fill_tag)
   );

   always_comb begin
      state_next     = state_reg;
      fill_addr_next = fill_addr_reg;
      cnt_next       = cnt_reg;
      drop_next      = drop_reg;
      done_next      = 1'b0;
      data_next      = data_reg;
      mreq_next      = mreq_reg;
      maddr_next     = maddr_reg;
      word_we        = 1'b0;
      tag_we         = 1'b0;
      line_inv       = 1'b0;
      case (state_reg)
         ICACHE_IDLE: begin
            // A request still held during the done cycle belongs to the fetch just answered.
            if (if_req_valid && !flush && !done_reg) begin
               if (hit) begin
                  data_next  = rd_data;
                  state_next = ICACHE_RESP;
               end else begin
                  fill_addr_next = if_req_addr[ADDR_WIDTH-1:ICACHE_WORD_LSB];
                  line_inv       = 1'b1;
                  cnt_next       = '0;
                  drop_next      = 1'b0;
                  mreq_next      = 1'b1;
                  maddr_next     = {if_req_addr[ADDR_WIDTH-1:INDEX_LSB],
                                    {LINE_WORDS_LOG{1'b0}}, {ICACHE_WORD_LSB{1'b0}}};
                  state_next     = ICACHE_FILL;
               end
            end
         end
         ICACHE_FILL: begin
            if (flush) drop_next = 1'b1;
            if (mem_resp_done) begin
               word_we = 1'b1;
               if (cnt_reg == fill_word) data_next = mem_resp_data;
               if (cnt_reg == LAST_WORD) begin
                  // A complete line is kept valid even when the fetch itself was abandoned.
                  tag_we     = 1'b1;
                  mreq_next  = 1'b0;
                  drop_next  = 1'b0;
                  state_next = (drop_reg || flush) ? ICACHE_IDLE : ICACHE_RESP;
               end else if (drop_reg || flush) begin
                  mreq_next  = 1'b0;
                  drop_next  = 1'b0;
                  state_next = ICACHE_IDLE;
               end else begin
                  cnt_next   = cnt_inc;
                  maddr_next = {fill_addr_reg[ADDR_WIDTH-1:INDEX_LSB], cnt_inc,
                                {ICACHE_WORD_LSB{1'b0}}};
               end
            end
         end
         ICACHE_RESP: begin
            done_next  = !flush;
            state_next = ICACHE_IDLE;
         end
         default: state_next = ICACHE_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ICACHE_IDLE;
         fill_addr_reg <= '0;
         cnt_reg       <= '0;
         drop_reg      <= 1'b0;
         done_reg      <= 1'b0;
         data_reg      <= '0;
         mreq_reg      <= 1'b0;
         maddr_reg     <= '0;
      end else if (rdy) begin
         state_reg     <= state_next;
         fill_addr_reg <= fill_addr_next;
         cnt_reg       <= cnt_next;
         drop_reg      <= drop_next;
         done_reg      <= done_next;
         data_reg      <= data_next;
         mreq_reg      <= mreq_next;
         maddr_reg     <= maddr_next;
      end
   end

   assign if_resp_done  = done_reg;
   assign if_resp_data  = data_reg;
   assign mem_req_valid = mreq_reg;
   assign mem_req_addr  = maddr_reg;

endmodule

// File: tb/tb_icache.sv
// Self-checking bench for icache: directed scenarios plus random fetches checked
// against a tag-table model of the cache and a procedural backing memory.
module tb_icache;

   logic        clk = 1'b0;
   logic        rst, rdy, flush, if_req_valid, mem_resp_done;
   logic [31:0] if_req_addr, mem_resp_data;
   logic        if_resp_done, mem_req_valid;
   logic [31:0] if_resp_data, mem_req_addr;

   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          last_resp_cyc = 0;
   bit          mem_auto = 1'b0;
   logic [31:0] mem_log[$];
   bit          mvalid[64];
   logic [21:0] mtag[64];

   icache dut (
      .clk           (clk),
      .rst           (rst),
      .rdy           (rdy),
      .flush         (flush),
      .if_req_valid  (if_req_valid),
      .if_req_addr   (if_req_addr),
      .if_resp_done  (if_resp_done),
      .if_resp_data  (if_resp_data),
      .mem_req_valid (mem_req_valid),
      .mem_req_addr  (mem_req_addr),
      .mem_resp_done (mem_resp_done),
      .mem_resp_data (mem_resp_data)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Backing memory contents: the first line returns 0xAAAA0001.. so the classic scenario is recognisable.
   function automatic logic [31:0] mem_val(input logic [31:0] a);
      if (a < 32'h20) return {16'hAAAA, 14'd0, a[3:2]} + 32'd1;
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Memory controller model with random response latency; disabled while the bench drives words by hand.
   initial begin
      int wait_n;
      wait_n = 0;
      mem_resp_done = 1'b0;
      mem_resp_data = '0;
      forever begin
         @(negedge clk);
         if (mem_auto) begin
            if (mem_req_valid && rdy && !rst) begin
               if (wait_n == 0) begin
                  mem_resp_done = 1'b1;
                  mem_resp_data = mem_val(mem_req_addr);
                  mem_log.push_back(mem_req_addr);
                  last_resp_cyc = cyc;
                  wait_n = $urandom_range(0, 3);
               end else begin
                  mem_resp_done = 1'b0;
                  wait_n--;
               end
            end else begin
               mem_resp_done = 1'b0;
            end
         end
      end
   end

   task automatic wait_done(output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         @(negedge clk);
         if (if_resp_done) seen = 1'b1;
      end
   endtask

   task automatic do_fetch(input logic [31:0] a);
      logic [31:0] base;
      int          idx, c0;
      logic [21:0] tg;
      bit          hit, seen;
      base = {a[31:4], 4'h0};
      idx  = int'(a[9:4]);
      tg   = a[31:10];
      hit  = mvalid[idx] && (mtag[idx] == tg);
      mem_log.delete();
      if_req_valid = 1'b1;
      if_req_addr  = a;
      c0 = cyc;
      wait_done(seen);
      chk("done_seen", 32'(seen), 32'd1);
      if (seen) begin
         chk("resp_data", if_resp_data, mem_val({a[31:2], 2'b00}));
         if (hit) begin
            chk("hit_latency", 32'(cyc - c0), 32'd2);
            chk("hit_no_mem", 32'(mem_log.size()), 32'd0);
         end else begin
            chk("miss_latency", 32'(cyc - last_resp_cyc), 32'd2);
            chk("refill_count", 32'(mem_log.size()), 32'd4);
            for (int k = 0; k < mem_log.size() && k < 4; k++)
               chk("refill_addr", mem_log[k], base + 32'(4 * k));
         end
      end
      @(negedge clk);
      chk("done_pulse", 32'(if_resp_done), 32'd0);
      if_req_valid = 1'b0;
      @(negedge clk);
      chk("held_req_ignored", {30'd0, if_resp_done, mem_req_valid}, 32'd0);
      mvalid[idx] = 1'b1;
      mtag[idx]   = tg;
      $display("fetch addr=%h %s data=%h", a, hit ? "hit " : "miss", if_resp_data);
   endtask

   task automatic start_miss(input logic [31:0] a);
      if_req_valid = 1'b1;
      if_req_addr  = a;
      @(negedge clk);
   endtask

   task automatic manual_word(input logic [31:0] exp_addr, input bit with_flush);
      chk("man_req_valid", 32'(mem_req_valid), 32'd1);
      chk("man_req_addr", mem_req_addr, exp_addr);
      mem_resp_done = 1'b1;
      mem_resp_data = mem_val(exp_addr);
      flush = with_flush;
      @(negedge clk);
      mem_resp_done = 1'b0;
      flush = 1'b0;
   endtask

   task automatic expect_quiet(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         chk(tag, {30'd0, if_resp_done, mem_req_valid}, 32'd0);
      end
   endtask

   initial begin
      bit seen;
      rst = 1'b1; rdy = 1'b1; flush = 1'b0; if_req_valid = 1'b0; if_req_addr = '0;
      for (int i = 0; i < 64; i++) begin mvalid[i] = 1'b0; mtag[i] = '0; end
      repeat (3) @(negedge clk);
      chk("rst_done", 32'(if_resp_done), 32'd0);
      chk("rst_data", if_resp_data, 32'd0);
      chk("rst_mreq", 32'(mem_req_valid), 32'd0);
      chk("rst_maddr", mem_req_addr, 32'd0);
      rst = 1'b0;
      mem_auto = 1'b1;
      @(negedge clk);

      // Cold miss, hit in the same line, conflicting tag, then the original line again.
      do_fetch(32'h0000_0010);
      do_fetch(32'h0000_0018);
      do_fetch(32'h0000_0410);
      do_fetch(32'h0000_0010);

      // Flush while the second refill word is outstanding.
      mem_auto = 1'b0;
      start_miss(32'h0000_0410);
      manual_word(32'h0000_0410, 1'b0);
      flush = 1'b1; if_req_valid = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_hold_req", 32'(mem_req_valid), 32'd1);
      chk("flush_hold_addr", mem_req_addr, 32'h0000_0414);
      manual_word(32'h0000_0414, 1'b0);
      chk("flush_drop_req", 32'(mem_req_valid), 32'd0);
      expect_quiet("flush_quiet", 4);
      mvalid[1] = 1'b0;
      $display("flush during refill of 0x410");
      mem_auto = 1'b1;
      do_fetch(32'h0000_0014);

      // Flush on the cycle of the final word: line kept, no response.
      mem_auto = 1'b0;
      start_miss(32'h0000_0820);
      manual_word(32'h0000_0820, 1'b0);
      manual_word(32'h0000_0824, 1'b0);
      manual_word(32'h0000_0828, 1'b0);
      if_req_valid = 1'b0;
      manual_word(32'h0000_082C, 1'b1);
      expect_quiet("flush_last_quiet", 3);
      mvalid[2] = 1'b1; mtag[2] = 22'd2;
      $display("flush on final word of 0x820");
      mem_auto = 1'b1;
      do_fetch(32'h0000_0828);

      // Flush in the response cycle of a hit, and together with a new request in IDLE.
      if_req_valid = 1'b1; if_req_addr = 32'h0000_0018;
      @(negedge clk);
      flush = 1'b1; if_req_valid = 1'b0;
      @(negedge clk);
      flush = 1'b0;
      chk("flush_resp_done", 32'(if_resp_done), 32'd0);
      expect_quiet("flush_resp_quiet", 2);
      if_req_valid = 1'b1; if_req_addr = 32'h0000_3000; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; if_req_valid = 1'b0;
      expect_quiet("flush_idle_quiet", 3);
      $display("flush in RESP and in IDLE");

      // Freeze with rdy=0 mid-refill.
      mem_auto = 1'b0;
      start_miss(32'h0000_1010);
      manual_word(32'h0000_1010, 1'b0);
      rdy = 1'b0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("frz_mreq", 32'(mem_req_valid), 32'd1);
         chk("frz_maddr", mem_req_addr, 32'h0000_1014);
         chk("frz_done", 32'(if_resp_done), 32'd0);
      end
      mem_log.delete();
      rdy = 1'b1;
      mem_auto = 1'b1;
      wait_done(seen);
      chk("frz_resume_done", 32'(seen), 32'd1);
      chk("frz_resume_data", if_resp_data, mem_val(32'h0000_1010));
      chk("frz_resume_count", 32'(mem_log.size()), 32'd3);
      for (int k = 0; k < mem_log.size() && k < 3; k++)
         chk("frz_resume_addr", mem_log[k], 32'h0000_1014 + 32'(4 * k));
      if_req_valid = 1'b0;
      @(negedge clk);
      mvalid[1] = 1'b1; mtag[1] = 22'd4;
      $display("rdy freeze during refill of 0x1010, data=%h", if_resp_data);

      // Reset in the middle of a refill invalidates everything.
      mem_auto = 1'b0;
      start_miss(32'h0000_2020);
      manual_word(32'h0000_2020, 1'b0);
      rst = 1'b1; if_req_valid = 1'b0;
      @(negedge clk);
      chk("rst_fill_mreq", 32'(mem_req_valid), 32'd0);
      chk("rst_fill_done", 32'(if_resp_done), 32'd0);
      rst = 1'b0;
      for (int i = 0; i < 64; i++) mvalid[i] = 1'b0;
      $display("reset during refill of 0x2020");
      mem_auto = 1'b1;
      @(negedge clk);
      do_fetch(32'h0000_1018);

      // Random fetches over a small tag/index pool to mix hits and conflicts.
      for (int t = 0; t < 40; t++) begin
         logic [31:0] a;
         a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 3)) << 4)
           | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
         do_fetch(a);
         repeat ($urandom_range(0, 2)) @(negedge clk);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
